// File: rtl/conv_map_reader.sv
// Captures one conv output map and streams it pixel by pixel in raster order,
// requantising each pixel (ReLU, rounding shift, saturate) for the dense stage.
module conv_map_reader #(
    parameter int H          = 12,
    parameter int W          = 11,
    parameter int CHAN       = 10,
    parameter int DATA_WIDTH = 24,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 8,
    parameter int RELU       = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    input  logic [3:0]                            in_chan,
    input  logic [H-1:0][W-1:0][DATA_WIDTH-1:0]   in_map,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic signed [OUT_WIDTH-1:0]           m_data,
    output logic [3:0]                            m_chan,
    output logic [3:0]                            m_row,
    output logic [3:0]                            m_col,
    output logic                                  m_last,
    output logic                                  frame_done,
    output logic                                  overflow,
    output logic                                  busy
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [DATA_WIDTH:0] RND =
        (SHIFT > 0) ? (DATA_WIDTH+1)'(2**SH1) : '0;
    localparam logic signed [DATA_WIDTH:0] SMAX =
        (DATA_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [DATA_WIDTH:0] SMIN = ~SMAX;

    state_t state;
    logic [H-1:0][W-1:0][DATA_WIDTH-1:0] map_q;
    logic [3:0] row, col, chan;
    logic xfer, at_end, last_xfer, capture;
    logic signed [DATA_WIDTH-1:0] px;
    logic signed [DATA_WIDTH:0]   x, y;
    logic signed [OUT_WIDTH-1:0]  q;

    assign xfer      = m_valid & m_ready;
    assign at_end    = (row == 4'(H-1)) && (col == 4'(W-1));
    assign last_xfer = xfer & at_end;
    // A map is accepted when idle, or exactly as the previous one drains.
    assign capture   = in_valid & ((state == IDLE) | last_xfer);

    always_ff @(posedge clk) begin
        if (capture)
            map_q <= in_map;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            chan       <= '0;
            m_valid    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= last_xfer && (chan == 4'(CHAN-1));
            if (in_valid && !capture)
                overflow <= 1'b1;
            if (capture) begin
                state   <= STREAM;
                chan    <= in_chan;
                row     <= '0;
                col     <= '0;
                m_valid <= 1'b1;
                busy    <= 1'b1;
            end else if (last_xfer) begin
                state   <= IDLE;
                row     <= '0;
                col     <= '0;
                m_valid <= 1'b0;
                busy    <= 1'b0;
            end else if (xfer) begin
                if (col == 4'(W-1)) begin
                    col <= '0;
                    row <= row + 4'd1;
                end else begin
                    col <= col + 4'd1;
                end
            end
        end
    end

    always_comb begin
        px = map_q[row][col];
        x  = {px[DATA_WIDTH-1], px};
        if (RELU != 0 && x < 0)
            x = '0;
        y = (SHIFT > 0) ? ((x + RND) >>> SHIFT) : x;
        if (y > SMAX)
            q = SMAX[OUT_WIDTH-1:0];
        else if (y < SMIN)
            q = SMIN[OUT_WIDTH-1:0];
        else
            q = y[OUT_WIDTH-1:0];
    end

    assign m_data = m_valid ? q : '0;
    assign m_chan = chan;
    assign m_row  = row;
    assign m_col  = col;
    assign m_last = m_valid & at_end;

endmodule

// File: tb/tb_conv_map_reader.sv
// Bench for conv_map_reader: random maps against an arithmetic requant model,
// with stalls, dropped maps, back-to-back maps and mid-stream reset.
module tb_conv_map_reader;

    localparam int H = 12;
    localparam int W = 11;
    localparam int N = H * W;

    typedef logic [H-1:0][W-1:0][23:0] map_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic m_ready = 1'b0;
    logic [3:0] in_chan = '0;
    map_t in_map = '0;

    logic m_valid, m_last, frame_done, overflow, busy;
    logic signed [7:0] m_data;
    logic [3:0] m_chan, m_row, m_col;

    logic v0, l0, fd0, ov0, b0;
    logic signed [7:0] d0;
    logic [3:0] c0, r0, k0;

    map_t cur, nxt;
    int tests = 0;
    int fails = 0;
    bit ovf = 1'b0;

    always #5 clk = ~clk;

    conv_map_reader u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_chan(in_chan),
        .in_map(in_map), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_chan(m_chan), .m_row(m_row), .m_col(m_col),
        .m_last(m_last), .frame_done(frame_done), .overflow(overflow),
        .busy(busy)
    );

    conv_map_reader #(.RELU(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_chan(in_chan),
        .in_map(in_map), .m_valid(v0), .m_ready(m_ready),
        .m_data(d0), .m_chan(c0), .m_row(r0), .m_col(k0),
        .m_last(l0), .frame_done(fd0), .overflow(ov0), .busy(b0)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ReLU, round-half-up division by 256, clamp to signed 8 bits.
    function automatic int rq(input int x, input bit relu);
        longint v = x;
        if (relu && v < 0) v = 0;
        v = v + 128;
        if (v >= 0) v = v / 256;
        else v = -((-v + 255) / 256);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return int'(v);
    endfunction

    function automatic logic [23:0] rpx();
        int v;
        case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 2000)) - 1000;
            1: v = int'($urandom_range(0, 80000)) - 40000;
            2: v = int'($urandom);
            default: v = int'($urandom_range(0, 200)) * 256 - 25600
                         + 127 + int'($urandom_range(0, 1));
        endcase
        return v[23:0];
    endfunction

    function automatic map_t rmap();
        map_t m;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                m[r][c] = rpx();
        return m;
    endfunction

    task automatic load(input logic [3:0] ch);
        in_map = cur;
        in_chan = ch;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_chan"}, m_chan, 0);
        chk({tag, "_row"}, m_row, 0);
        chk({tag, "_col"}, m_col, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_fdone"}, frame_done, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_u0"}, {v0, d0, c0, r0, k0, l0, fd0, ov0, b0}, 0);
    endtask

    // mode: 0 always ready, 1 ready 1,0,0 repeating, 2 random ready.
    task automatic stream(input logic [3:0] ch, input int mode, input int drop_at,
                          input bit chain, input logic [3:0] nch, input int stop_at);
        int k = 0;
        int cyc = 0;
        int lim = (stop_at >= 0) ? stop_at : N;
        bit dropped = 1'b0;
        while (k < lim && cyc < 3000) begin
            int r = k / W;
            int c = k % W;
            int px = int'($signed(cur[r][c]));
            m_ready = (mode == 0) ? 1'b1 :
                      (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            chk($sformatf("valid_b%0d", k), m_valid, 1);
            chk($sformatf("busy_b%0d", k), busy, 1);
            chk($sformatf("row_b%0d", k), m_row, r);
            chk($sformatf("col_b%0d", k), m_col, c);
            chk($sformatf("chan_b%0d", k), m_chan, ch);
            chk($sformatf("last_b%0d", k), m_last, (k == N - 1));
            chk($sformatf("data_b%0d", k), m_data, rq(px, 1'b1));
            chk($sformatf("data_norelu_b%0d", k), d0, rq(px, 1'b0));
            if (k == drop_at && !dropped) begin
                dropped = 1'b1;
                in_map = nxt;
                in_chan = ch ^ 4'd1;
                in_valid = 1'b1;
                ovf = 1'b1;
            end
            if (m_ready) begin
                if (chain && k == N - 1) begin
                    in_map = nxt;
                    in_chan = nch;
                    in_valid = 1'b1;
                end
                k++;
            end
            cyc++;
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("stream_complete", k, lim);
        if (stop_at < 0) begin
            chk("frame_done_pulse", frame_done, (ch == 4'd9));
            if (chain) begin
                chk("chain_no_bubble", m_valid, 1);
                chk("chain_row", m_row, 0);
                chk("chain_col", m_col, 0);
                chk("chain_chan", m_chan, nch);
            end else begin
                chk("end_valid", m_valid, 0);
                chk("end_busy", busy, 0);
                @(negedge clk);
                chk("frame_done_clear", frame_done, 0);
            end
            chk("overflow", overflow, ovf);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                cur[r][c] = 24'd256;
        load(4'd3);
        stream(4'd3, 0, -1, 1'b0, 4'd0, -1);

        cur = rmap();
        cur[0][0] = 24'd384;
        cur[0][1] = 24'd383;
        cur[0][2] = 24'h7FFFFF;
        cur[0][3] = 24'hFFFED4;
        cur[0][4] = 24'h800000;
        cur[0][5] = 24'd32767;
        load(4'd5);
        stream(4'd5, 1, -1, 1'b0, 4'd0, -1);

        cur = rmap();
        load(4'd9);
        stream(4'd9, 2, -1, 1'b0, 4'd0, -1);

        cur = rmap();
        nxt = rmap();
        load(4'd9);
        stream(4'd9, 0, -1, 1'b1, 4'd4, -1);
        cur = nxt;
        nxt = rmap();
        stream(4'd4, 2, 50, 1'b0, 4'd0, -1);

        cur = rmap();
        load(4'd7);
        stream(4'd7, 0, -1, 1'b0, 4'd0, 70);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("post_reset_idle");

        cur = rmap();
        load(4'd12);
        stream(4'd12, 1, -1, 1'b0, 4'd0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
